// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared funct3 codes, ram write strobe encodings and address width.
package load_store_unit_pkg;
  localparam int DEF_RAM_ADDR_BITS = 11;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;
  function automatic logic [2:0] we_onehot(input logic [1:0] size);
    return size == 2'b00 ? WE_BYTE : size == 2'b01 ? WE_HALF : WE_WORD;
  endfunction
endpackage

// File: rtl/load_store_unit_extend.sv
// load_extend: sign/zero-extends the ram's low byte/half into a 32-bit load result.
//   funct3 in 3, rdata in 32 (selected byte/half in low bits), result out 32.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b = rdata[7:0];
  assign w_h = rdata[15:0];
  always_comb begin
    result = funct3 == F3_B  ? {{24{w_b[7]}}, w_b} :
             funct3 == F3_BU ? {24'b0, w_b} :
             funct3 == F3_H  ? {{16{w_h[15]}}, w_h} :
             funct3 == F3_HU ? {16'b0, w_h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns load/store requests into ram strobes, absorbs ram read latency, returns one response per request.
//   req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata : request handshake from execute stage
//   resp_valid/resp_ready/resp_rdata/resp_err                   : response handshake (held until taken)
//   mem_addr/mem_wdata/mem_we/mem_rdata                          : ram port (1-cycle registered read)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_we,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_rdata;
  logic [2:0]  r_funct3;
  logic        r_err;
  logic        w_accept, w_bad_f3, w_misal, w_range, w_err;
  logic [31:0] w_ext;
  load_extend u_ext (.funct3(r_funct3), .rdata(mem_rdata), .result(w_ext));
  assign req_ready  = r_state == IDLE;
  assign w_accept   = req_valid && req_ready;
  assign w_bad_f3   = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (req_store && req_funct3[2]);
  assign w_misal    = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign w_range    = |req_addr[31:RAM_ADDR_BITS];
  assign w_err      = w_bad_f3 || w_misal || w_range;
  // Strobes are forced low during reset so the ram sees no access while rst_n is held.
  assign mem_addr   = !rst_n ? 32'b0 : r_state == IDLE ? req_addr : r_addr;
  assign mem_we     = rst_n && w_accept && req_store && !w_err ? we_onehot(req_funct3[1:0]) : 3'b0;
  assign mem_wdata  = req_wdata;
  assign resp_valid = r_state == RESP;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_accept ? IDLE : (req_store || w_err) ? RESP : READ;
      READ:    w_next = RESP;
      RESP:    w_next = resp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr   <= req_addr;
        r_funct3 <= req_funct3;
        r_err    <= w_err;
        r_rdata  <= '0;
      end
      if (r_state == READ) r_rdata <= w_ext;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load_store_unit paired with a byte-addressed ram model.
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_we;
  logic [7:0]  ram [0:2047];
  logic [10:0] a;
  int          n_vec = 0, n_err = 0, we_cycles = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign a = mem_addr[10:0];
  initial for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_we != 3'b0) we_cycles <= we_cycles + 1;
    if (mem_we[0]) begin
      ram[a] <= mem_wdata[7:0]; ram[a + 11'd1] <= mem_wdata[15:8];
      ram[a + 11'd2] <= mem_wdata[23:16]; ram[a + 11'd3] <= mem_wdata[31:24];
    end
    if (mem_we[1]) begin
      ram[a] <= mem_wdata[7:0]; ram[a + 11'd1] <= mem_wdata[15:8];
    end
    if (mem_we[2]) ram[a] <= mem_wdata[7:0];
    mem_rdata <= {ram[a + 11'd3], ram[a + 11'd2], ram[a + 11'd1], ram[a]};
  end

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output logic [2:0] we);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = ad; req_wdata = wd; resp_ready = 1'b1;
    #1 we = mem_we;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic test_reset;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0040; req_wdata = 32'h1234_5678;
    #12;
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    n_vec++; if (resp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    n_vec++; if (resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    n_vec++; if (mem_we !== 3'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 000", mem_we); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store_load;
    logic [31:0] rd; logic er; int lat; logic [2:0] we;
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat, we);
    n_vec++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b0 || we !== 3'b001) begin
      n_err++; $display("FAIL sw_0x10 got lat=%0d rd=%h err=%b we=%b want lat=1 rd=0 err=0 we=001", lat, rd, er, we); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, we);
    n_vec++; if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || we !== 3'b000) begin
      n_err++; $display("FAIL lw_0x10 got lat=%0d rd=%h err=%b we=%b want lat=2 rd=deadbeef err=0 we=000", lat, rd, er, we); end
  endtask

  task automatic test_extend;
    logic [31:0] rd; logic er; int lat; logic [2:0] we;
    logic [2:0]  f3s [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b100, 3'b000};
    logic [31:0] ads [7] = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h11, 32'h13, 32'h13};
    logic [31:0] exp [7] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01,
                             32'h0000_007F, 32'h0000_0080, 32'hFFFF_FF80};
    issue(1'b1, 3'b010, 32'h10, 32'h80FF_7F01, rd, er, lat, we);
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, f3s[i], ads[i], 32'h0, rd, er, lat, we);
      n_vec++; if (lat !== 2 || rd !== exp[i] || er !== 1'b0) begin
        n_err++; $display("FAIL ext_%0d f3=%b @%h got lat=%0d rd=%h err=%b want lat=2 rd=%h err=0", i, f3s[i], ads[i], lat, rd, er, exp[i]); end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd, e; logic er; int lat; logic [2:0] we;
    e = 32'h0;
    issue(1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat, we);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 3'b000, 32'h20 + i, 32'h1234_56AA, rd, er, lat, we);
      n_vec++; if (we !== 3'b100 || er !== 1'b0 || lat !== 1) begin
        n_err++; $display("FAIL sb_lane%0d got we=%b err=%b lat=%0d want we=100 err=0 lat=1", i, we, er, lat); end
      e = e | (32'hAA << (8 * i));
      issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, we);
      n_vec++; if (rd !== e) begin n_err++; $display("FAIL lw_lane%0d got %h want %h", i, rd, e); end
    end
    issue(1'b1, 3'b001, 32'h26, 32'h5555_BEEF, rd, er, lat, we);
    n_vec++; if (we !== 3'b010 || er !== 1'b0) begin n_err++; $display("FAIL sh_0x26 got we=%b err=%b want we=010 err=0", we, er); end
    issue(1'b0, 3'b010, 32'h24, 32'h0, rd, er, lat, we);
    n_vec++; if (rd !== 32'hBEEF_0000) begin n_err++; $display("FAIL lw_0x24 got %h want beef0000", rd); end
    issue(1'b1, 3'b010, 32'h7FC, 32'h0123_4567, rd, er, lat, we);
    issue(1'b0, 3'b010, 32'h7FC, 32'h0, rd, er, lat, we);
    n_vec++; if (rd !== 32'h0123_4567 || er !== 1'b0) begin n_err++; $display("FAIL lw_0x7fc got rd=%h err=%b want 01234567 err=0", rd, er); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat; logic [2:0] we; int w0;
    logic        sts [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [6] = '{3'b001, 3'b010, 3'b010, 3'b011, 3'b100, 3'b000};
    logic [31:0] ads [6] = '{32'h11, 32'h22, 32'h800, 32'h20, 32'h20, 32'h8000_0020};
    w0 = we_cycles;
    for (int i = 0; i < 6; i++) begin
      issue(sts[i], f3s[i], ads[i], 32'h1111_1111, rd, er, lat, we);
      n_vec++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || we !== 3'b0) begin
        n_err++; $display("FAIL err_%0d st=%b f3=%b @%h got err=%b rd=%h lat=%0d we=%b want err=1 rd=0 lat=1 we=000", i, sts[i], f3s[i], ads[i], er, rd, lat, we); end
    end
    n_vec++; if (we_cycles !== w0) begin n_err++; $display("FAIL err_we_cycles got %0d want %0d", we_cycles, w0); end
    issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, we);
    n_vec++; if (rd !== 32'hAAAA_AAAA || er !== 1'b0) begin n_err++; $display("FAIL err_mem_unchanged got rd=%h err=%b want aaaaaaaa err=0", rd, er); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic er; int lat; logic [2:0] we; int n;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; resp_ready = 1'b0;
    @(negedge clk);
    req_store = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
    n = 0;
    while (!resp_valid && n < 10) begin @(negedge clk); n++; end
    n_vec++; if (n !== 1) begin n_err++; $display("FAIL bp_latency got %0d extra cycles want 1", n); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h80FF_7F01 || req_ready !== 1'b0 || mem_we !== 3'b0) begin
        n_err++; $display("FAIL bp_hold%0d got valid=%b rd=%h ready=%b we=%b want 1 80ff7f01 0 000", i, resp_valid, resp_rdata, req_ready, mem_we); end
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, we);
    n_vec++; if (lat !== 2 || rd !== 32'h80FF_7F01) begin n_err++; $display("FAIL bp_next got lat=%0d rd=%h want 2 80ff7f01", lat, rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; logic er; int lat; logic [2:0] we; logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0 || mem_addr !== 32'h10) begin
      n_err++; $display("FAIL mid_in_read got ready=%b addr=%h want 0 00000010", req_ready, mem_addr); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (resp_valid !== 1'b0 || mem_addr !== 32'h0 || req_ready !== 1'b1 || resp_rdata !== 32'h0) begin
      n_err++; $display("FAIL mid_async got valid=%b addr=%h ready=%b rd=%h want 0 0 1 0", resp_valid, mem_addr, req_ready, resp_rdata); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); seen |= resp_valid; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_stale got resp_valid=%b want 0", seen); end
    issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat, we);
    n_vec++; if (lat !== 2 || rd !== 32'hAAAA_AAAA || er !== 1'b0) begin
      n_err++; $display("FAIL mid_first_lw got lat=%0d rd=%h err=%b want 2 aaaaaaaa 0", lat, rd, er); end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_extend;
    test_byte_lanes;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
